// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite slave front end:
//   - AXI response codes
//   - write / read channel FSM state encodings
//   - is_aligned(): word-alignment test on the two byte-address LSBs
// ---------------------------------------------------------------------------
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_ISSUE = 2'd1,
      W_WAIT  = 2'd2,
      W_RESP  = 2'd3
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_ISSUE = 2'd1,
      R_WAIT  = 2'd2,
      R_RESP  = 2'd3
   } rd_state_t;

   // 32-bit registers only: any byte offset inside a word is rejected.
   function automatic logic is_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// ---------------------------------------------------------------------------
// axil_timeout_ctr
// 8-bit response watchdog for one channel.
//   i_clk / i_rst_n : clock, asynchronous active-low reset
//   i_clear         : restart the count (asserted with the local strobe)
//   i_enable        : count while waiting for the local return
//   o_expired       : high in the waiting cycle where count == TIMEOUT-1
// ---------------------------------------------------------------------------
module axil_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_count <= '0;
      else if (i_clear)  r_count <= '0;
      else if (i_enable) r_count <= r_count + 8'd1;
   end

   assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/axil_slave_port.sv
// ---------------------------------------------------------------------------
// axil_slave_port
// AXI4-Lite slave front end. Each accepted AXI transaction becomes one
// single-cycle local write/read strobe; the local done/error return (or a
// timeout) is turned into the B/R response. Write and read channels are
// fully independent, one outstanding transaction each.
//
// Ports
//   s_axi_aclk, s_axi_aresetn          clock, async active-low reset
//   s_axi_aw*/w*/b*                     AXI write address/data/response
//   s_axi_ar*/r*                        AXI read address/data
//   write, write_addrs/data/strobe      local write strobe + held payload
//   write_done, write_error             local write return
//   read, read_addrs                    local read strobe + held address
//   read_data, read_done, read_error    local read return
// ---------------------------------------------------------------------------
module axil_slave_port
   import axil_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   // AW / W / B
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   // AR / R
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [DATA_W-1:0] s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   // local write side
   output logic              write,
   output logic [ADDR_W-1:0] write_addrs,
   output logic [DATA_W-1:0] write_data,
   output logic [3:0]        write_strobe,
   input  logic              write_done,
   input  logic              write_error,
   // local read side
   output logic              read,
   output logic [ADDR_W-1:0] read_addrs,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_done,
   input  logic              read_error
);

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   wr_state_t         r_wst, w_wst_nxt;
   logic              r_aw_held, w_aw_held_nxt;
   logic              r_w_held,  w_w_held_nxt;
   logic [ADDR_W-1:0] r_awaddr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_awready, r_wready;
   logic [1:0]        r_bresp, w_bresp_nxt;

   logic w_aw_hs, w_w_hs, w_wr_aligned, w_wr_go, w_wr_expired;

   assign w_aw_hs      = s_axi_awvalid && r_awready;
   assign w_w_hs       = s_axi_wvalid  && r_wready;
   assign w_wr_aligned = is_aligned(r_awaddr[1:0]);
   // Strobe only for aligned writes with at least one byte enabled.
   assign w_wr_go      = (r_wst == W_ISSUE) && w_wr_aligned && (r_wstrb != 4'h0);

   always_comb begin
      w_wst_nxt     = r_wst;
      w_bresp_nxt   = r_bresp;
      w_aw_held_nxt = r_aw_held;
      w_w_held_nxt  = r_w_held;
      case (r_wst)
         W_IDLE: begin
            if (w_aw_hs) w_aw_held_nxt = 1'b1;
            if (w_w_hs)  w_w_held_nxt  = 1'b1;
            // Issue as soon as both halves are in, whichever came last.
            if (w_aw_held_nxt && w_w_held_nxt) w_wst_nxt = W_ISSUE;
         end
         W_ISSUE: begin
            w_aw_held_nxt = 1'b0;
            w_w_held_nxt  = 1'b0;
            if (!w_wr_aligned) begin
               w_wst_nxt   = W_RESP;
               w_bresp_nxt = RESP_SLVERR;
            end else if (r_wstrb == 4'h0) begin
               w_wst_nxt   = W_RESP;
               w_bresp_nxt = RESP_OKAY;
            end else begin
               w_wst_nxt   = W_WAIT;
            end
         end
         W_WAIT: begin
            // error outranks done; timeout only matters with no return
            if (write_error) begin
               w_wst_nxt   = W_RESP;
               w_bresp_nxt = RESP_SLVERR;
            end else if (write_done) begin
               w_wst_nxt   = W_RESP;
               w_bresp_nxt = RESP_OKAY;
            end else if (w_wr_expired) begin
               w_wst_nxt   = W_RESP;
               w_bresp_nxt = RESP_SLVERR;
            end
         end
         W_RESP: begin
            if (s_axi_bready) w_wst_nxt = W_IDLE;
         end
         default: w_wst_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_wst     <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_wst     <= w_wst_nxt;
         r_aw_held <= w_aw_held_nxt;
         r_w_held  <= w_w_held_nxt;
         r_bresp   <= w_bresp_nxt;
         if (w_aw_hs) r_awaddr <= s_axi_awaddr;
         if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
         end
         // Registered readies: computed from the next state so they drop
         // the cycle after capture and reappear on return to idle.
         r_awready <= (w_wst_nxt == W_IDLE) && !w_aw_held_nxt;
         r_wready  <= (w_wst_nxt == W_IDLE) && !w_w_held_nxt;
      end
   end

   axil_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wr_tmo (
      .i_clk     (s_axi_aclk),
      .i_rst_n   (s_axi_aresetn),
      .i_clear   (w_wr_go),
      .i_enable  (r_wst == W_WAIT),
      .o_expired (w_wr_expired)
   );

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = (r_wst == W_RESP);
   assign s_axi_bresp   = r_bresp;
   assign write         = w_wr_go;
   assign write_addrs   = r_awaddr;
   assign write_data    = r_wdata;
   assign write_strobe  = r_wstrb;

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   rd_state_t         r_rst, w_rst_nxt;
   logic [ADDR_W-1:0] r_araddr;
   logic              r_arready;
   logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
   logic [1:0]        r_rresp, w_rresp_nxt;

   logic w_ar_hs, w_rd_aligned, w_rd_go, w_rd_expired;

   assign w_ar_hs      = s_axi_arvalid && r_arready;
   assign w_rd_aligned = is_aligned(r_araddr[1:0]);
   assign w_rd_go      = (r_rst == R_ISSUE) && w_rd_aligned;

   always_comb begin
      w_rst_nxt   = r_rst;
      w_rdata_nxt = r_rdata;
      w_rresp_nxt = r_rresp;
      case (r_rst)
         R_IDLE: begin
            if (w_ar_hs) w_rst_nxt = R_ISSUE;
         end
         R_ISSUE: begin
            if (!w_rd_aligned) begin
               w_rst_nxt   = R_RESP;
               w_rresp_nxt = RESP_SLVERR;
               w_rdata_nxt = '0;
            end else begin
               w_rst_nxt   = R_WAIT;
            end
         end
         R_WAIT: begin
            if (read_error || (!read_done && w_rd_expired)) begin
               w_rst_nxt   = R_RESP;
               w_rresp_nxt = RESP_SLVERR;
               w_rdata_nxt = '0;
            end else if (read_done) begin
               w_rst_nxt   = R_RESP;
               w_rresp_nxt = RESP_OKAY;
               w_rdata_nxt = read_data;
            end
         end
         R_RESP: begin
            if (s_axi_rready) w_rst_nxt = R_IDLE;
         end
         default: w_rst_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_rst     <= R_IDLE;
         r_araddr  <= '0;
         r_arready <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_rst     <= w_rst_nxt;
         r_rdata   <= w_rdata_nxt;
         r_rresp   <= w_rresp_nxt;
         if (w_ar_hs) r_araddr <= s_axi_araddr;
         r_arready <= (w_rst_nxt == R_IDLE);
      end
   end

   axil_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_rd_tmo (
      .i_clk     (s_axi_aclk),
      .i_rst_n   (s_axi_aresetn),
      .i_clear   (w_rd_go),
      .i_enable  (r_rst == R_WAIT),
      .o_expired (w_rd_expired)
   );

   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = (r_rst == R_RESP);
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign read          = w_rd_go;
   assign read_addrs    = r_araddr;

endmodule
